// File: rtl/z80_bus_initiator.sv
// ----------------------------------------------------------------------------
// z80_bus_initiator
//
// Z80-style bus cycle generator. It takes a single request (read or write,
// memory or I/O) and plays it out on a Z80-like strobe bus as T1, T2, optional
// wait states (TW), and T3. Each T-state lasts CLKDIV clocks. A DONE state
// signals completion for one clock.
//
// wait_n is an asynchronous input. It passes through a two-flop synchronizer
// and is only looked at on the last clock of T2 and of each TW. I/O cycles
// always insert one extra TW. If the target holds wait_n low for WAIT_TIMEOUT
// counted wait states, the cycle is aborted.
//
// Parameters
//   CLKDIV        clk cycles per T-state (2..255)
//   WAIT_TIMEOUT  counted TW states tolerated before abort (1..255)
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   req                 request strobe, looked at only when not busy
//   req_we, req_io      write/read and I/O/memory select
//   req_addr, req_wdata cycle address and write data
//   busy                high from T1 through T3
//   done                one-clock completion pulse
//   timeout             qualifies done: the cycle was aborted (held until the
//                       next accept)
//   rdata               read result (8'hFF after an abort)
//   address             bus address (holds its last value when idle)
//   data_out, data_oe   bus write data and its tristate enable
//   data_in             bus data from the pads
//   mreq_n, ioreq_n     active-low memory / I/O request strobes
//   rd_n, wr_n          active-low read / write strobes
//   wait_n              asynchronous active-low wait from the target
// ----------------------------------------------------------------------------
module z80_bus_initiator #(
    parameter int CLKDIV       = 4,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic [15:0] address,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_n,
    output logic        ioreq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n
);

    localparam int          SYNC_STAGES = 2;
    localparam logic [7:0]  PRESC_LAST  = 8'(CLKDIV - 1);
    localparam logic [7:0]  TW_LIMIT    = 8'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // wait_n synchronizer. Both flops reset to 1 (bus not waiting).
    // ------------------------------------------------------------------
    logic sync_in  [SYNC_STAGES];
    logic sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_in[gi] = wait_n;
            end else begin : g_rest
                assign sync_in[gi] = sync_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_in[gi];
                end
            end
        end
    endgenerate

    logic wait_sample;
    assign wait_sample = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_reg,   state_next;
    logic [7:0]  presc_reg,   presc_next;
    logic [7:0]  tw_cnt_reg,  tw_cnt_next;
    logic        forced_reg,  forced_next;   // current TW is the I/O forced one
    logic        we_reg,      we_next;
    logic        io_reg,      io_next;
    logic [15:0] addr_reg,    addr_next;
    logic [7:0]  wdata_reg,   wdata_next;
    logic [7:0]  rdata_reg,   rdata_next;
    logic        timeout_reg, timeout_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= 8'd0;
            tw_cnt_reg  <= 8'd0;
            forced_reg  <= 1'b0;
            we_reg      <= 1'b0;
            io_reg      <= 1'b0;
            addr_reg    <= 16'h0000;
            wdata_reg   <= 8'h00;
            rdata_reg   <= 8'h00;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            tw_cnt_reg  <= tw_cnt_next;
            forced_reg  <= forced_next;
            we_reg      <= we_next;
            io_reg      <= io_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            timeout_reg <= timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic timed_state;
    logic last_tick;

    assign timed_state = (state_reg == ST_T1) || (state_reg == ST_T2) ||
                         (state_reg == ST_TW) || (state_reg == ST_T3);
    assign last_tick   = timed_state && (presc_reg == PRESC_LAST);

    always_comb begin
        state_next   = state_reg;
        tw_cnt_next  = tw_cnt_reg;
        forced_next  = forced_reg;
        we_next      = we_reg;
        io_next      = io_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        timeout_next = timeout_reg;

        // Every timed state ends on its last tick, so clearing the prescaler
        // there also clears it on entry to the next state (including TW->TW).
        if (timed_state && !last_tick) begin
            presc_next = presc_reg + 8'd1;
        end else begin
            presc_next = 8'd0;
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    state_next   = ST_T1;
                    we_next      = req_we;
                    io_next      = req_io;
                    addr_next    = req_addr;
                    wdata_next   = req_wdata;
                    timeout_next = 1'b0;
                    tw_cnt_next  = 8'd0;
                    forced_next  = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_T1: begin
                if (last_tick) begin
                    state_next = ST_T2;
                end
            end

            ST_T2: begin
                if (last_tick) begin
                    if (io_reg) begin
                        // I/O always gets one uncounted wait state.
                        state_next  = ST_TW;
                        forced_next = 1'b1;
                        tw_cnt_next = 8'd0;
                    end else if (!wait_sample) begin
                        state_next  = ST_TW;
                        forced_next = 1'b0;
                        tw_cnt_next = 8'd1;
                    end else begin
                        state_next = ST_T3;
                    end
                end
            end

            ST_TW: begin
                if (last_tick) begin
                    if (wait_sample) begin
                        state_next  = ST_T3;
                        forced_next = 1'b0;
                    end else if (forced_reg) begin
                        state_next  = ST_TW;
                        forced_next = 1'b0;
                        tw_cnt_next = 8'd1;
                    end else if (tw_cnt_reg >= TW_LIMIT) begin
                        // Target never released wait_n: abandon the cycle.
                        state_next   = ST_DONE;
                        timeout_next = 1'b1;
                        rdata_next   = 8'hFF;
                    end else begin
                        state_next  = ST_TW;
                        tw_cnt_next = tw_cnt_reg + 8'd1;
                    end
                end
            end

            ST_T3: begin
                if (last_tick) begin
                    state_next = ST_DONE;
                    if (!we_reg) begin
                        rdata_next = data_in;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state so they are glitch-free
    // relative to the state register.
    // ------------------------------------------------------------------
    logic strobe_phase;
    assign strobe_phase = (state_reg == ST_T2) || (state_reg == ST_TW) ||
                          (state_reg == ST_T3);

    assign busy     = timed_state;
    assign done     = (state_reg == ST_DONE);
    assign timeout  = timeout_reg;
    assign rdata    = rdata_reg;
    assign address  = addr_reg;
    assign data_out = wdata_reg;
    assign data_oe  = timed_state && we_reg;
    assign mreq_n   = !(strobe_phase && !io_reg);
    assign ioreq_n  = !(strobe_phase &&  io_reg);
    assign rd_n     = !(strobe_phase && !we_reg);
    assign wr_n     = !(strobe_phase &&  we_reg);

endmodule

// File: tb/tb_z80_bus_initiator.sv
// ----------------------------------------------------------------------------
// tb_z80_bus_initiator
//
// Directed and randomized bench for z80_bus_initiator (CLKDIV=4,
// WAIT_TIMEOUT=4). Each bus cycle is described by its kind (read/write,
// memory/I/O) and by how many wait_n samples the target holds low. The
// expected timing is computed arithmetically from T-state counts, then the
// whole cycle is observed clock by clock and compared.
// ----------------------------------------------------------------------------
module tb_z80_bus_initiator;

    localparam int CLKDIV       = 4;
    localparam int WAIT_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_we;
    logic        req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  rdata;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        mreq_n;
    logic        ioreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        wait_n;

    int tests = 0;
    int fails = 0;
    logic [7:0] model_rdata;   // what rdata should hold after the last cycle

    z80_bus_initiator #(
        .CLKDIV      (CLKDIV),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_we   (req_we),
        .req_io   (req_io),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .rdata    (rdata),
        .address  (address),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in),
        .mreq_n   (mreq_n),
        .ioreq_n  (ioreq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .wait_n   (wait_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle clocks between cycles: nothing may be busy or completing.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_done", done, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    // Runs one bus cycle. Called at #1 after an edge, in an IDLE or DONE
    // clock; the next edge is the accepting one. n_low = number of decisive
    // wait_n samples the target keeps low. Returns in the DONE clock.
    task automatic run_txn(input string name, input logic we, input logic io,
                           input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rv, input int n_low, input bit noise);
        int  tw_total, timed, exp_lat, first_dec, rel, t3s, k;
        bit  aborted, got_done;
        int  busy_cnt, oe_cnt, req_lo, other_req_lo, dir_lo, other_dir_lo;
        int  addr_bad, dout_bad;
        logic [7:0] exp_rd;

        // Reference expectations from T-state arithmetic.
        aborted   = (n_low > WAIT_TIMEOUT);
        tw_total  = (io ? 1 : 0) + (aborted ? WAIT_TIMEOUT : n_low);
        timed     = CLKDIV * ((aborted ? 2 : 3) + tw_total);
        exp_lat   = timed + 1;
        first_dec = io ? 3 * CLKDIV : 2 * CLKDIV;   // edge of first decisive sample
        // Sample at edge D sees wait_n as driven at edge D-2 (two sync flops).
        rel       = first_dec + CLKDIV * n_low - 3;
        t3s       = CLKDIV * (2 + tw_total);
        exp_rd    = aborted ? 8'hFF : (we ? model_rdata : rv);

        req       = 1'b1;
        req_we    = we;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wd;
        wait_n    = 1'b0;     // low ahead of the sample points must not matter
        data_in   = ~rv;
        tick();               // accepting edge
        req = 1'b0;

        busy_cnt = 0; oe_cnt = 0; req_lo = 0; other_req_lo = 0;
        dir_lo = 0; other_dir_lo = 0; addr_bad = 0; dout_bad = 0;
        got_done = 1'b0;
        k = 0;
        while (k < 400) begin
            if (k == 0) begin
                check({name, "_accept_busy"}, busy, 1'b1);
                check({name, "_accept_timeout_clr"}, timeout, 1'b0);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            busy_cnt     += int'(busy);
            oe_cnt       += int'(data_oe);
            req_lo       += int'(io ? !ioreq_n : !mreq_n);
            other_req_lo += int'(io ? !mreq_n : !ioreq_n);
            dir_lo       += int'(we ? !wr_n : !rd_n);
            other_dir_lo += int'(we ? !rd_n : !wr_n);
            if (busy && address !== addr) addr_bad++;
            if (data_oe && data_out !== wd) dout_bad++;
            if (k == rel) wait_n = 1'b1;
            if (k == t3s) data_in = rv;
            if (noise) begin
                req       = 1'($urandom);
                req_we    = 1'($urandom);
                req_io    = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end
            tick();
            k++;
        end
        req = 1'b0;

        check({name, "_done_seen"}, got_done, 1'b1);
        if (!got_done) return;

        check({name, "_latency"}, k + 1, exp_lat);
        check({name, "_busy_clks"}, busy_cnt, timed);
        check({name, "_oe_clks"}, oe_cnt, we ? timed : 0);
        check({name, "_req_strobe_clks"}, req_lo, timed - CLKDIV);
        check({name, "_dir_strobe_clks"}, dir_lo, timed - CLKDIV);
        check({name, "_other_req_clks"}, other_req_lo, 0);
        check({name, "_other_dir_clks"}, other_dir_lo, 0);
        check({name, "_addr_bad"}, addr_bad, 0);
        check({name, "_dout_bad"}, dout_bad, 0);
        check({name, "_done_busy"}, busy, 1'b0);
        check({name, "_done_strobes"}, {mreq_n, ioreq_n, rd_n, wr_n, data_oe}, 5'b11110);
        check({name, "_rdata"}, rdata, exp_rd);
        check({name, "_timeout"}, timeout, aborted);
        $display("[TB] %s we=%0d io=%0d addr=%04h wd=%02h n_low=%0d lat=%0d rdata=%02h timeout=%0d",
                 name, we, io, addr, wd, n_low, k + 1, rdata, timeout);
        model_rdata = exp_rd;

        // Target still holding wait_n after an abort: release it later.
        while (k < rel) begin
            tick();
            k++;
            check({name, "_tail_done"}, done, 1'b0);
        end
        wait_n  = 1'b1;
        data_in = 8'h00;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        req       = 1'b1;     // must be ignored while reset is high
        req_we    = 1'b1;
        req_io    = 1'b0;
        req_addr  = 16'hBEEF;
        req_wdata = 8'h77;
        data_in   = 8'h00;
        wait_n    = 1'b1;
        model_rdata = 8'h00;

        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_address", address, 16'h0000);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_strobes", {mreq_n, ioreq_n, rd_n, wr_n}, 4'b1111);
        req   = 1'b0;
        reset = 1'b0;
        idle(2);

        // Directed cycles.
        run_txn("mem_rd", 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);
        idle(2);
        run_txn("mem_wr", 1'b1, 1'b0, 16'h8000, 8'h3C, 8'h00, 0, 1'b0);
        idle(2);
        run_txn("io_rd", 1'b0, 1'b1, 16'h00FE, 8'h00, 8'h5A, 0, 1'b0);
        idle(2);
        run_txn("mem_rd_3w", 1'b0, 1'b0, 16'h4321, 8'h00, 8'hC3, 3, 1'b0);
        idle(2);
        run_txn("mem_rd_stuck", 1'b0, 1'b0, 16'h2222, 8'h00, 8'h11, 6, 1'b0);
        idle(2);
        run_txn("io_wr_2w", 1'b1, 1'b1, 16'h0042, 8'h99, 8'h00, 2, 1'b1);
        idle(1);

        // Reset in the middle of a wait state: cycle is dropped silently.
        req = 1'b1; req_we = 1'b0; req_io = 1'b0; req_addr = 16'h5555;
        wait_n = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 0; i < 2 * CLKDIV + 2; i++) tick();   // now inside TW
        check("rst_tw_in_tw", {busy, mreq_n, rd_n}, 3'b100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_n = 1'b1;
        check("rst_tw_strobes", {mreq_n, ioreq_n, rd_n, wr_n}, 4'b1111);
        check("rst_tw_busy", busy, 1'b0);
        check("rst_tw_done", done, 1'b0);
        model_rdata = 8'h00;
        idle(6 * CLKDIV);
        check("rst_tw_rdata", rdata, 8'h00);

        // Back-to-back: second request presented in the DONE clock.
        run_txn("b2b_first", 1'b0, 1'b0, 16'hA000, 8'h00, 8'h3E, 0, 1'b0);
        run_txn("b2b_second", 1'b1, 1'b0, 16'hA001, 8'hE3, 8'h00, 1, 1'b0);
        idle(2);

        // Randomized cycles.
        for (int t = 0; t < 30; t++) begin
            n = int'($urandom_range(0, 6));
            run_txn($sformatf("rand%0d", t), 1'($urandom), 1'($urandom),
                    16'($urandom), 8'($urandom), 8'($urandom), n, 1'($urandom));
            if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/z80_bus_initiator.md
Z80_BUS_INITIATOR -- requirements
Module: z80_bus_initiator

Interface
REQ-001 SHALL have parameter CLKDIV, default 4: clk cycles per T-state; legal range 2..255.
REQ-002 SHALL have parameter WAIT_TIMEOUT, default 64: maximum consecutive TW states before abort; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock, from the internal oscillator; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: request strobe, sampled only while busy=0.
REQ-006 SHALL have port req_we, input, 1: 1 selects a write cycle, 0 a read cycle.
REQ-007 SHALL have port req_io, input, 1: 1 selects an I/O cycle (ioreq_n), 0 a memory cycle (mreq_n).
REQ-008 SHALL have port req_addr, input, 16: cycle address.
REQ-009 SHALL have port req_wdata, input, 8: write data.
REQ-010 SHALL have port busy, output, 1: a cycle is in progress.
REQ-011 SHALL have port done, output, 1: one-clk completion pulse.
REQ-012 SHALL have port timeout, output, 1: qualifies done; the cycle was aborted.
REQ-013 SHALL have port rdata, output, 8: read result, valid from done until the next accept.
REQ-014 SHALL have port address, output, 16: bus address.
REQ-015 SHALL have port data_out, output, 8: bus write data.
REQ-016 SHALL have port data_oe, output, 1: tristate enable for data_out.
REQ-017 SHALL have port data_in, input, 8: bus data from pads.
REQ-018 SHALL have ports mreq_n, ioreq_n, rd_n and wr_n, outputs, 1 each: active-low strobes.
REQ-019 SHALL have port wait_n, input, 1: asynchronous active-low wait from the target.

Function
REQ-020 SHALL implement states IDLE, T1, T2, TW, T3, DONE; each of T1/T2/TW/T3 lasts exactly CLKDIV clks, timed by a prescaler that is cleared on each state entry.
REQ-021 SHALL accept a request on the edge where req=1 and state is IDLE, capturing req_we, req_io, req_addr and req_wdata, and enter T1 on the next clk.
REQ-022 SHALL ignore req while busy=1; no queuing.
REQ-023 SHALL drive address from the captured value from T1 through T3, and hold its last value in IDLE.
REQ-024 In T1, all strobes SHALL be high; for writes, data_out SHALL equal the captured data and data_oe=1.
REQ-025 In T2, TW and T3, the selected request strobe (mreq_n or ioreq_n) SHALL be low, together with rd_n (read) or wr_n (write); the other strobes SHALL stay high.
REQ-026 For writes, data_oe SHALL be 1 from T1 through T3; for reads, data_oe SHALL be 0 at all times.
REQ-027 wait_n SHALL pass through a 2-flop synchronizer; the synchronized value is sampled on the last clk of T2 and of each TW.
REQ-028 A sampled value of 0 SHALL enter or repeat TW; a value of 1 SHALL go to T3.
REQ-029 An I/O cycle SHALL always insert one forced TW after T2, independent of wait_n; wait_n sampling then continues per REQ-027 and REQ-028.
REQ-030 On a read, rdata SHALL latch data_in on the last clk of T3.
REQ-031 On the clk after the last T3 clk, all strobes SHALL go high, data_oe=0, and the block SHALL enter DONE.
REQ-032 In DONE: done=1 for exactly one clk and busy=0; the next state is IDLE.
REQ-033 A req present in the DONE clk SHALL be accepted (back-to-back cycles).
REQ-034 busy SHALL be 1 from T1 through T3.
REQ-035 Latency SHALL be: done asserted 3*CLKDIV+1 clks after the accepting edge, plus CLKDIV per TW.
REQ-036 A TW counter SHALL count consecutive TW states (forced TW excluded).
REQ-037 When the counter reaches WAIT_TIMEOUT and the sample is still 0, the block SHALL abort: strobes high, data_oe=0, rdata=8'hFF, enter DONE with timeout=1.
REQ-038 timeout SHALL hold its value until the next accept, which clears it to 0.
REQ-039 wait_n SHALL have no effect outside T2/TW sampling points.

Reset
REQ-040 On the clk edge with reset=1: state IDLE, prescaler and TW counter 0, busy=0, done=0, timeout=0, rdata=8'h00, address=16'h0000, data_out=8'h00, data_oe=0, and all strobes high; synchronizer flops set to 1.
REQ-041 Reset SHALL take priority over every transition, including mid-cycle; no done pulse SHALL be produced for an interrupted cycle.
REQ-042 req SHALL be ignored while reset=1.

Verification
REQ-043 Memory read, CLKDIV=4, addr 16'h1234, wait_n=1, target drives 8'hA5 -> mreq_n/rd_n low for 8 clks, done at accept+13, rdata=8'hA5, timeout=0.
REQ-044 Memory write, addr 16'h8000, data 8'h3C -> data_oe=1 for 12 clks, wr_n low for 8 clks, rd_n stays high, done at accept+13.
REQ-045 I/O read, addr 16'h00FE, wait_n=1 -> ioreq_n low while mreq_n stays high, one forced TW, done at accept+17.
REQ-046 Memory read with wait_n held low for 3 T-state samples -> 3 TW states, done at accept+25, correct rdata.
REQ-047 wait_n stuck low, WAIT_TIMEOUT=4 -> abort after 4 TW states, done with timeout=1, rdata=8'hFF, strobes high.
REQ-048 Reset asserted in TW, plus req held high in the DONE clk -> reset case: strobes high, busy=0 and no done on the next clk; DONE case: the next cycle begins T1 with no idle gap.
